// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the pc_write polarity, the default bubble word and a PC alignment helper.
package if_fetch_unit_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  // Level of pc_write meaning "IF/ID advances this cycle"
  localparam logic PC_WRITE_ON = 1'b1;

  // Default instruction presented as a bubble
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Sequential fetch stride in bytes
  localparam logic [31:0] PC_STEP = 32'd4;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry fetch buffer holding an instruction word and its PC+4.
// Priority on each edge: flush > fill > accept.
import if_fetch_unit_pkg::*;

module if_fetch_buf #(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        fill_i,
  input  logic        accept_i,
  input  logic [31:0] fill_word_i,
  input  logic [31:0] fill_pc4_i,
  output logic [31:0] buf_word_o,
  output logic [31:0] buf_pc4_o,
  output logic        buf_valid_o
);

  logic [31:0] word_q, word_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Next-state selection: a redirect flush wins, then a refill, then consumption
  always_comb begin
    word_d  = word_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      word_d  = fill_word_i;
      pc4_d   = fill_pc4_i;
      valid_d = 1'b1;
    end else if (accept_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign buf_word_o  = word_q;
  assign buf_pc4_o   = pc4_q;
  assign buf_valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, requests words from instruction
// memory over a req/ack handshake, and presents them to IF/ID through a
// one-entry buffer. Redirects abandon in-flight requests via a DRAIN state.
// Optional build macro IF_ALIGN_CHECK_EN: flags misaligned redirect targets
// in the sticky align_err output; otherwise align_err is tied low.
import if_fetch_unit_pkg::*;

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus4_out,
  output logic        fetch_valid,
  output logic        fetch_stall,
  output logic        align_err
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  drain_addr_q;

  logic [31:0]  buf_word;
  logic [31:0]  buf_pc4;
  logic         buf_valid;

  logic         accept;
  logic         xfer;
  logic         fill;
  logic [31:0]  target_aligned;

  assign accept         = (pc_write == PC_WRITE_ON) & buf_valid;
  assign xfer           = imem_req & imem_ack;
  assign fill           = xfer & (state_q == FETCH_FETCH) & ~redirect_valid;
  assign target_aligned = pc_align(redirect_target);

  // Request/address decode; req must react to pc_write in the same cycle so
  // a consumed word is replaced without a bubble
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_align(fetch_pc_q);
    case (state_q)
      FETCH_FETCH: imem_req = ~buf_valid | accept;
      FETCH_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = pc_align(drain_addr_q);
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch FSM and PC: redirect has priority; an unacked request at redirect
  // time is carried to completion in DRAIN with its original address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= target_aligned;
      if (imem_req && !imem_ack) begin
        state_q <= FETCH_DRAIN;
        if (state_q != FETCH_DRAIN) begin
          drain_addr_q <= imem_addr;
        end
      end else begin
        state_q <= FETCH_FETCH;
      end
    end else begin
      case (state_q)
        FETCH_IDLE: state_q <= FETCH_FETCH;
        FETCH_FETCH: begin
          if (xfer) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
          end
        end
        FETCH_DRAIN: begin
          if (xfer) begin
            state_q <= FETCH_FETCH;
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  if_fetch_buf #(
    .NOP_WORD(NOP_WORD)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .fill_i     (fill),
    .accept_i   (accept),
    .fill_word_i(imem_rdata),
    .fill_pc4_i (fetch_pc_q + PC_STEP),
    .buf_word_o (buf_word),
    .buf_pc4_o  (buf_pc4),
    .buf_valid_o(buf_valid)
  );

  assign instruction_out = buf_valid ? buf_word : NOP_WORD;
  assign pc_plus4_out    = buf_pc4;
  assign fetch_valid     = buf_valid;
  assign fetch_stall     = ~buf_valid;

`ifdef IF_ALIGN_CHECK_EN
  logic align_err_q;

  // Sticky flag for redirect targets that are not word aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      align_err_q <= 1'b0;
    end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      align_err_q <= 1'b1;
    end
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit. Memory returns 32'hA000_0000 | addr
// when acked, so every expected instruction is derived from a known address.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus4_out;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        align_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

`ifdef IF_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_ALIGN = 32'd1;
`else
  localparam logic [31:0] EXP_ALIGN = 32'd0;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruction_out(instruction_out),
    .pc_plus4_out   (pc_plus4_out),
    .fetch_valid    (fetch_valid),
    .fetch_stall    (fetch_stall),
    .align_err      (align_err)
  );

  // Instruction memory model
  assign imem_rdata = imem_ack ? (32'hA000_0000 | imem_addr) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leave time 1 after the edge and log the cycle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: req=%0b addr=%h valid=%0b instr=%h pc4=%h align=%0b",
             cyc, imem_req, imem_addr, fetch_valid, instruction_out, pc_plus4_out, align_err);
  endtask

  initial begin
    rst             = 1'b1;
    pc_write        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    imem_ack        = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_instr", instruction_out, 32'h0000_0000);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_stall", {31'd0, fetch_stall}, 32'd1);
    check("rst_pc4",   pc_plus4_out, 32'd0);
    check("rst_align", {31'd0, align_err}, 32'd0);
    rst = 1'b0;

    // Streaming with ack tied high
    tick();  // IDLE -> FETCH
    check("s1_req",   {31'd0, imem_req}, 32'd1);
    check("s1_addr",  imem_addr, 32'h0);
    check("s1_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("s2_instr", instruction_out, 32'hA000_0000);
    check("s2_pc4",   pc_plus4_out, 32'd4);
    check("s2_addr",  imem_addr, 32'd4);
    check("s2_valid", {31'd0, fetch_valid}, 32'd1);
    tick();
    check("s3_instr", instruction_out, 32'hA000_0004);
    check("s3_pc4",   pc_plus4_out, 32'd8);
    check("s3_addr",  imem_addr, 32'd8);
    tick();
    check("s4_instr", instruction_out, 32'hA000_0008);
    check("s4_pc4",   pc_plus4_out, 32'd12);

    // Ack withheld for three edges
    imem_ack = 1'b0;
    tick();
    check("w1_valid", {31'd0, fetch_valid}, 32'd0);
    check("w1_instr", instruction_out, 32'h0);
    check("w1_req",   {31'd0, imem_req}, 32'd1);
    check("w1_addr",  imem_addr, 32'd12);
    tick();
    check("w2_addr",  imem_addr, 32'd12);
    check("w2_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("w3_addr",  imem_addr, 32'd12);
    imem_ack = 1'b1;
    tick();
    check("w4_instr", instruction_out, 32'hA000_000C);
    check("w4_pc4",   pc_plus4_out, 32'd16);

    // Hold with full buffer
    pc_write = 1'b0;
    #1;
    check("h0_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("h1_instr", instruction_out, 32'hA000_000C);
    check("h1_pc4",   pc_plus4_out, 32'd16);
    check("h1_req",   {31'd0, imem_req}, 32'd0);
    tick();
    check("h2_instr", instruction_out, 32'hA000_000C);
    check("h2_req",   {31'd0, imem_req}, 32'd0);
    pc_write = 1'b1;
    #1;
    check("h3_req",  {31'd0, imem_req}, 32'd1);
    check("h3_addr", imem_addr, 32'd16);
    tick();
    check("h4_instr", instruction_out, 32'hA000_0010);
    check("h4_pc4",   pc_plus4_out, 32'd20);

    // Redirect while a request is pending and unacked
    imem_ack = 1'b0;
    tick();
    check("d0_addr",  imem_addr, 32'd20);
    check("d0_valid", {31'd0, fetch_valid}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("d1_req",   {31'd0, imem_req}, 32'd1);
    check("d1_addr",  imem_addr, 32'd20);
    check("d1_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("d2_addr", imem_addr, 32'd20);
    imem_ack = 1'b1;
    tick();
    check("d3_valid", {31'd0, fetch_valid}, 32'd0);
    check("d3_instr", instruction_out, 32'h0);
    check("d3_addr",  imem_addr, 32'h100);
    tick();
    check("d4_instr", instruction_out, 32'hA000_0100);
    check("d4_pc4",   pc_plus4_out, 32'h104);

    // Redirect coinciding with xfer and accept
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("r1_valid", {31'd0, fetch_valid}, 32'd0);
    check("r1_addr",  imem_addr, 32'h200);
    tick();
    check("r2_instr", instruction_out, 32'hA000_0200);
    check("r2_pc4",   pc_plus4_out, 32'h204);

    // PC wrap at top of address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("x1_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("x2_instr", instruction_out, 32'hFFFF_FFFC);
    check("x2_pc4",   pc_plus4_out, 32'h0);
    check("x2_addr",  imem_addr, 32'h0);

    // Misaligned redirect target
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("a1_addr",  imem_addr, 32'h100);
    check("a1_align", {31'd0, align_err}, EXP_ALIGN);
    tick();
    check("a2_align", {31'd0, align_err}, EXP_ALIGN);
    check("a2_instr", instruction_out, 32'hA000_0100);
    rst = 1'b1;
    tick();
    check("a3_align", {31'd0, align_err}, 32'd0);
    check("a3_req",   {31'd0, imem_req}, 32'd0);
    check("a3_valid", {31'd0, fetch_valid}, 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
